// File: rtl/wb_uart_lite.sv
// wb_uart_lite: Wishbone classic 8-bit slave UART, 8N1 TX behind a small FIFO, one-byte RX holding register.
// Latency: each access terminates (ack or err) one cycle after cyc&stb is sampled; TX starts the edge after a push.
// Backpressure: none on the bus; DATA writes while the TX FIFO is full are acked and the byte is dropped.
module wb_uart_lite #(
    parameter int CLKS_PER_BIT  = 16,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        int_o
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(TX_FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(TX_FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic       ack_q, err_q;
    logic [7:0] dat_q, dat_d;
    logic       bus_req, adr_ok, tx_push, rx_pop, stat_rd;
    logic [7:0] status;

    logic [7:0]      fifo_mem_q [TX_FIFO_DEPTH];
    logic [AW-1:0]   fifo_wr_q, fifo_rd_q;
    logic [CNTW-1:0] fifo_cnt_q;
    logic            fifo_vld, tx_full, fifo_push, tx_pop, tx_idle;

    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_cnt_end;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_cnt_end, stop_smp, rx_load;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;

    logic unused_ok;
    assign unused_ok = ^{wb_adr_i[31:3], wb_cti_i, wb_bte_i};

    // A new request is only taken while no termination is showing, so each access costs >= 2 cycles.
    assign bus_req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign adr_ok  = (wb_adr_i[2:1] == 2'b00);
    assign tx_push = bus_req & (wb_adr_i[2:0] == 3'd0) & wb_we_i;
    assign rx_pop  = bus_req & (wb_adr_i[2:0] == 3'd0) & ~wb_we_i;
    assign stat_rd = bus_req & (wb_adr_i[2:0] == 3'd1) & ~wb_we_i;
    assign status  = {3'b000, frame_err_q, overrun_q, tx_idle, tx_full, rx_valid_q};

    always_comb begin
        dat_d = '0;
        if (bus_req & adr_ok & ~wb_we_i)
            dat_d = wb_adr_i[0] ? status : rx_data_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= bus_req & adr_ok;
            err_q <= bus_req & ~adr_ok;
            dat_q <= dat_d;
        end
    end

    assign fifo_vld  = (fifo_cnt_q != '0);
    assign tx_full   = (fifo_cnt_q == FIFO_FULL);
    assign fifo_push = tx_push & ~tx_full;
    assign tx_idle   = ~fifo_vld & (tx_state_q == S_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) fifo_wr_q <= fifo_wr_q + AW'(1);
            if (tx_pop)    fifo_rd_q <= fifo_rd_q + AW'(1);
            fifo_cnt_q <= fifo_cnt_q + CNTW'(fifo_push) - CNTW'(tx_pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fifo_push) fifo_mem_q[fifo_wr_q] <= wb_dat_i;
    end

    assign tx_cnt_end = (tx_cnt_q == BIT_END);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (fifo_vld) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_mem_q[fifo_rd_q];
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_cnt_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_cnt_end) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                end
            end
            default: begin
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_cnt_end) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit so queued frames are gapless.
                    if (fifo_vld) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_mem_q[fifo_rd_q];
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_cnt_end = (rx_cnt_q == BIT_END);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        stop_smp   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q & ~rx_sync_q) rx_state_d = S_START;
            end
            S_START: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            default: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    stop_smp   = 1'b1;
                    rx_state_d = S_IDLE;
                end
            end
        endcase
    end

    // A pop on the same edge frees the holding register, so the new byte lands without overrun.
    assign rx_load = stop_smp & rx_sync_q & (~rx_valid_q | rx_pop);

    always_comb begin
        rx_data_d   = rx_load ? rx_shift_q : rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (rx_pop)  rx_valid_d = 1'b0;
        if (rx_load) rx_valid_d = 1'b1;
        if (stat_rd) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (stop_smp & rx_sync_q & rx_valid_q & ~rx_pop) overrun_d = 1'b1;
        if (stop_smp & ~rx_sync_q) frame_err_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign int_o    = rx_valid_q;
    assign tx_o     = (tx_state_q == S_START) ? 1'b0 :
                      (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;
endmodule

// File: tb/tb_wb_uart_lite.sv
// Bench for wb_uart_lite: TX frames decoded by a line monitor against a byte scoreboard, RX bytes against a read scoreboard.
`timescale 1ns/1ps
module tb_wb_uart_lite;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr;
    logic [7:0]  wb_dat_w, wb_dat_r;
    logic        wb_we, wb_cyc, wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack, wb_err, wb_rty;
    logic        tx_line, rx_line, irq;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    bit         chk_contig = 1'b0;
    bit         prev_valid = 1'b0;
    int         prev_end   = 0;

    logic [9:0] mon_bits;
    bit         mon_hold_ok, mon_abort;
    int         mon_t0;
    logic [7:0] mon_exp;

    logic [7:0] rd;
    logic       ak, er;
    int         lt;
    bit         ok;
    logic [7:0] exp_b;

    wb_uart_lite #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
        .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_cti_i(wb_cti),
        .wb_bte_i(wb_bte), .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
        .wb_rty_o(wb_rty), .tx_o(tx_line), .rx_i(rx_line), .int_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // TX line monitor: decodes each frame from per-cycle samples and checks it against tx_exp_q.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && tx_line === 1'b0) begin
                mon_t0 = cyc_n; mon_hold_ok = 1'b1; mon_abort = 1'b0; mon_bits = '0;
                for (int b = 0; b < 10 && !mon_abort; b++) begin
                    for (int s = 0; s < CPB && !mon_abort; s++) begin
                        if (b != 0 || s != 0) begin @(posedge clk); #1; end
                        if (rst_n !== 1'b1) mon_abort = 1'b1;
                        else if (s == 0) mon_bits[b] = tx_line;
                        else if (tx_line !== mon_bits[b]) mon_hold_ok = 1'b0;
                    end
                end
                if (!mon_abort) begin
                    checks++;
                    if (!mon_hold_ok) begin errors++; $display("FAIL tx_bit_hold: bit level changed inside a bit period, frame at cycle %0d", mon_t0); end
                    checks++;
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin errors++; $display("FAIL tx_framing: start=%b stop=%b expected start=0 stop=1", mon_bits[0], mon_bits[9]); end
                    if (chk_contig && prev_valid) begin
                        checks++;
                        if (mon_t0 != prev_end + 1) begin errors++; $display("FAIL tx_contig: frame started cycle %0d expected %0d", mon_t0, prev_end + 1); end
                    end
                    prev_end = cyc_n; prev_valid = 1'b1;
                    checks++;
                    if (tx_exp_q.size() == 0) begin
                        errors++; $display("FAIL tx_unexpected: got frame %h expected no frame", mon_bits[8:1]);
                    end else begin
                        mon_exp = tx_exp_q.pop_front();
                        if (mon_bits[8:1] !== mon_exp) begin errors++; $display("FAIL tx_data: got %h expected %h", mon_bits[8:1], mon_exp); end
                    end
                end
            end
        end
    end

    task automatic bus_access(input logic [31:0] adr, input logic we, input logic [7:0] wdat,
                              output logic [7:0] rdat, output logic got_ack, output logic got_err, output int lat);
        @(posedge clk); #1;
        wb_adr = adr; wb_we = we; wb_dat_w = wdat; wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
        while (lat < 8 && !got_ack && !got_err) begin
            @(posedge clk); #1;
            lat++;
            got_ack = wb_ack; got_err = wb_err; rdat = wb_dat_r;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wait_tx_empty(input int bound, output bit done);
        int n = 0;
        while (tx_exp_q.size() != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        done = (tx_exp_q.size() == 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] data, input logic stop_lvl);
        logic [9:0] frame;
        frame = {stop_lvl, data, 1'b0};
        @(posedge clk); #1;
        for (int b = 0; b < 10; b++) begin
            rx_line = frame[b];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        wb_cti = 3'b111; wb_bte = 2'b11; rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wb_ack, wb_err, wb_rty, irq, tx_line} !== 5'b00001) begin errors++; $display("FAIL reset_ctrl: got %b expected 00001", {wb_ack, wb_err, wb_rty, irq, tx_line}); end
        checks++;
        if (wb_dat_r !== 8'h00) begin errors++; $display("FAIL reset_dat: got %h expected 00", wb_dat_r); end
        rst_n = 1'b1; wb_adr = 32'd1; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_r !== 8'h04) begin errors++; $display("FAIL reset_first_access: got ack=%b dat=%h expected ack=1 dat=04", wb_ack, wb_dat_r); end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_tx_byte();
        tx_exp_q.push_back(8'h55);
        bus_access(32'd0, 1'b1, 8'h55, rd, ak, er, lt);
        checks++;
        if (ak !== 1'b1 || er !== 1'b0 || lt != 1) begin errors++; $display("FAIL tx_wr_ack: got ack=%b err=%b lat=%0d expected ack=1 err=0 lat=1", ak, er, lt); end
        checks++;
        if (tx_line !== 1'b1) begin errors++; $display("FAIL tx_pre_start: got %b expected 1", tx_line); end
        @(posedge clk); #1;
        checks++;
        if (tx_line !== 1'b0) begin errors++; $display("FAIL tx_start_edge: got %b expected 0", tx_line); end
        checks++;
        if (wb_ack !== 1'b0 || wb_dat_r !== 8'h00) begin errors++; $display("FAIL ack_one_cycle: got ack=%b dat=%h expected ack=0 dat=00", wb_ack, wb_dat_r); end
        wait_tx_empty(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_drain: got %0d bytes pending expected 0", tx_exp_q.size()); end
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (ak !== 1'b1 || rd !== 8'h04) begin errors++; $display("FAIL tx_idle_status: got ack=%b dat=%h expected ack=1 dat=04", ak, rd); end
    endtask

    task automatic test_fifo_full();
        chk_contig = 1'b1; prev_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tx_exp_q.push_back(8'(i));
            bus_access(32'd0, 1'b1, 8'(i), rd, ak, er, lt);
            checks++;
            if (ak !== 1'b1 || lt != 1) begin errors++; $display("FAIL fifo_wr_ack%0d: got ack=%b lat=%0d expected ack=1 lat=1", i, ak, lt); end
        end
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h02) begin errors++; $display("FAIL fifo_full_status: got %h expected 02", rd); end
        bus_access(32'd0, 1'b1, 8'h06, rd, ak, er, lt);
        checks++;
        if (ak !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL fifo_drop_ack: got ack=%b err=%b expected ack=1 err=0", ak, er); end
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h02) begin errors++; $display("FAIL fifo_still_full: got %h expected 02", rd); end
        wait_tx_empty(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fifo_drain: got %0d bytes pending expected 0", tx_exp_q.size()); end
        chk_contig = 1'b0;
        repeat (60) @(posedge clk);
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h04) begin errors++; $display("FAIL fifo_after_status: got %h expected 04", rd); end
    endtask

    task automatic test_rx_overrun();
        rx_exp_q.push_back(8'hA3);
        send_rx(8'hA3, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_int: got %b expected 1", irq); end
        send_rx(8'h3C, 1'b1);
        repeat (6) @(posedge clk);
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h0D) begin errors++; $display("FAIL rx_overrun_status: got %h expected 0D", rd); end
        bus_access(32'd0, 1'b0, 8'h00, rd, ak, er, lt);
        exp_b = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'hxx;
        checks++;
        if (ak !== 1'b1 || rd !== exp_b) begin errors++; $display("FAIL rx_data_a3: got ack=%b dat=%h expected ack=1 dat=%h", ak, rd, exp_b); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_int_clear: got %b expected 0", irq); end
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h04) begin errors++; $display("FAIL rx_flags_cleared: got %h expected 04", rd); end
    endtask

    task automatic test_frame_err();
        send_rx(8'hFF, 1'b0);
        rx_line = 1'b1;
        repeat (6) @(posedge clk);
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h14 || irq !== 1'b0) begin errors++; $display("FAIL frame_err_status: got dat=%h int=%b expected dat=14 int=0", rd, irq); end
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h04) begin errors++; $display("FAIL frame_err_clear: got %h expected 04", rd); end
        @(posedge clk); #1 rx_line = 1'b0;
        @(posedge clk); #1 rx_line = 1'b1;
        repeat (20) @(posedge clk);
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h04 || irq !== 1'b0) begin errors++; $display("FAIL false_start: got dat=%h int=%b expected dat=04 int=0", rd, irq); end
        rx_exp_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        repeat (6) @(posedge clk);
        bus_access(32'd0, 1'b0, 8'h00, rd, ak, er, lt);
        exp_b = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'hxx;
        checks++;
        if (rd !== exp_b) begin errors++; $display("FAIL rx_data_5a: got %h expected %h", rd, exp_b); end
    endtask

    task automatic test_bus_err();
        bus_access(32'd3, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (er !== 1'b1 || ak !== 1'b0 || lt != 1 || rd !== 8'h00) begin errors++; $display("FAIL bus_err_rd: got err=%b ack=%b lat=%0d dat=%h expected err=1 ack=0 lat=1 dat=00", er, ak, lt, rd); end
        @(posedge clk); #1;
        checks++;
        if (wb_err !== 1'b0 || wb_ack !== 1'b0) begin errors++; $display("FAIL bus_err_one_cycle: got err=%b ack=%b expected 0 0", wb_err, wb_ack); end
        bus_access(32'd7, 1'b1, 8'h99, rd, ak, er, lt);
        checks++;
        if (er !== 1'b1 || ak !== 1'b0) begin errors++; $display("FAIL bus_err_wr: got err=%b ack=%b expected err=1 ack=0", er, ak); end
        bus_access(32'd1, 1'b1, 8'hFF, rd, ak, er, lt);
        checks++;
        if (ak !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL status_wr_ack: got ack=%b err=%b expected ack=1 err=0", ak, er); end
        repeat (20) @(posedge clk);
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (rd !== 8'h04 || tx_line !== 1'b1) begin errors++; $display("FAIL bus_err_no_effect: got status=%h tx=%b expected status=04 tx=1", rd, tx_line); end
    endtask

    task automatic test_reset_mid();
        bus_access(32'd0, 1'b1, 8'h00, rd, ak, er, lt);
        bus_access(32'd0, 1'b1, 8'h7E, rd, ak, er, lt);
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (tx_line !== 1'b0) begin errors++; $display("FAIL mid_bit3_level: got %b expected 0", tx_line); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_line !== 1'b1 || irq !== 1'b0 || wb_ack !== 1'b0) begin errors++; $display("FAIL async_reset: got tx=%b int=%b ack=%b expected tx=1 int=0 ack=0", tx_line, irq, wb_ack); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_access(32'd1, 1'b0, 8'h00, rd, ak, er, lt);
        checks++;
        if (ak !== 1'b1 || rd !== 8'h04) begin errors++; $display("FAIL post_reset_status: got ack=%b dat=%h expected ack=1 dat=04", ak, rd); end
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (tx_line !== 1'b1) begin errors++; $display("FAIL queue_flushed: got tx=%b expected 1", tx_line); end
    endtask

    initial begin
        test_reset();
        test_tx_byte();
        test_fifo_full();
        test_rx_overrun();
        test_frame_err();
        test_bus_err();
        test_reset_mid();
        checks++;
        if (tx_exp_q.size() != 0) begin errors++; $display("FAIL tx_scoreboard_left: got %0d expected 0", tx_exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
